// File: rtl/uart_pkg.sv
// uart_pkg: register word offsets, STATUS bit positions and the shared TX/RX state encoding.
package uart_pkg;
  localparam logic [1:0] REG_CTRL = 2'd0, REG_TXDATA = 2'd1, REG_STATUS = 2'd2, REG_BAUDDIV = 2'd3;
  localparam int ST_BUSY = 0, ST_RX_VALID = 1, ST_FRAME_ERR = 2, ST_OVERRUN = 3, ST_RX_DATA = 8;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
endpackage

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serializer, 16 baud ticks per bit; abort forces the line idle at once.
module uart_tx
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] tx_byte,
  output logic       txd,
  output logic       tx_busy
);
  uart_state_e state;
  logic [3:0] tcnt;
  logic [2:0] bitn;
  logic [7:0] sh;
  logic       bit_end;
  assign bit_end = tcnt == 4'hf;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      tcnt  <= '0;
      bitn  <= '0;
      sh    <= '0;
    end else if (abort) begin
      state <= IDLE;
      tcnt  <= '0;
      bitn  <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        state <= START;
        sh    <= tx_byte;
        tcnt  <= '0;
        bitn  <= '0;
      end
    end else if (tick) begin
      tcnt  <= tcnt + 4'd1;
      state <= !bit_end ? state : state == START ? DATA : state == STOP ? IDLE : bitn == 3'd7 ? STOP : DATA;
      sh    <= bit_end && state == DATA ? sh >> 1 : sh;
      bitn  <= bit_end && state == DATA ? bitn + 3'd1 : bitn;
    end
  assign txd     = state == DATA ? sh[0] : state != START;
  assign tx_busy = state != IDLE;
endmodule

// File: rtl/uart_top.sv
// uart_top: 4-word memory-mapped UART (CTRL, TXDATA, STATUS, BAUDDIV) with 16x baud tick.
// Define UART_RX_EN to build the receiver and its STATUS fields.
module uart_top
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  output logic        txd,
  input  logic        sel,
  input  logic [13:0] addr,
  input  logic [3:0]  we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic        hit, wr_ctrl, wr_tx, wr_baud;
  logic        uart_en, en_d, start_q, tick, tx_busy;
  logic [7:0]  tx_data;
  logic [31:0] baud, cnt, status;
  logic        rx_valid, frame_err, overrun;
  logic [7:0]  rx_data;
  assign hit     = sel && addr[13:2] == 12'd0;
  assign wr_ctrl = hit && addr[1:0] == REG_CTRL && we[0];
  assign wr_tx   = hit && addr[1:0] == REG_TXDATA && we[0];
  assign wr_baud = hit && addr[1:0] == REG_BAUDDIV;
  assign en_d    = wr_ctrl ? wdata[0] : uart_en;
  // BAUDDIV of 0 or 1 both compare true on every clock
  assign tick    = uart_en && ({1'b0, cnt} + 33'd1 >= {1'b0, baud});
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      uart_en <= 1'b0;
      tx_data <= '0;
      start_q <= 1'b0;
      baud    <= '0;
      cnt     <= '0;
    end else begin
      uart_en <= en_d;
      if (wr_tx) tx_data <= wdata[7:0];
      start_q <= wr_tx && uart_en && !tx_busy && !start_q;
      for (int i = 0; i < 4; i++)
        if (wr_baud && we[i]) baud[8*i +: 8] <= wdata[8*i +: 8];
      cnt <= !en_d || start_q || tick ? '0 : cnt + 32'd1;
    end
  uart_tx u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .start   (start_q),
    .abort   (!en_d),
    .tx_byte (tx_data),
    .txd     (txd),
    .tx_busy (tx_busy)
  );
`ifdef UART_RX_EN
  logic        s1, s2, s_prev, rx_wait, wr_st, rx_load, rx_ferr;
  uart_state_e rx_state;
  logic [3:0]  rtcnt;
  logic [2:0]  rbit;
  logic [7:0]  rsh;
  assign wr_st   = hit && addr[1:0] == REG_STATUS && we[0];
  assign rx_load = en_d && tick && rx_state == STOP && rtcnt == 4'hf && s2;
  assign rx_ferr = en_d && tick && rx_state == STOP && rtcnt == 4'hf && !s2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {s1, s2, s_prev} <= 3'b111;
      rx_state <= IDLE;
      rtcnt    <= '0;
      rbit     <= '0;
      rsh      <= '0;
      rx_wait  <= 1'b0;
    end else begin
      {s1, s2, s_prev} <= {rxd, s1, s2};
      if (!en_d) begin
        rx_state <= IDLE;
        rtcnt    <= '0;
        rbit     <= '0;
        rx_wait  <= 1'b0;
      end else if (rx_state == IDLE) begin
        rx_wait <= rx_wait && !s2;
        if (!rx_wait && s_prev && !s2) begin
          rx_state <= START;
          rtcnt    <= '0;
          rbit     <= '0;
        end
      end else if (tick) begin
        rtcnt <= rx_state == START && rtcnt == 4'd7 ? 4'd0 : rtcnt + 4'd1;
        if (rx_state == START && rtcnt == 4'd7) rx_state <= s2 ? IDLE : DATA;
        if (rx_state == DATA && rtcnt == 4'hf) begin
          rsh  <= {s2, rsh[7:1]};
          rbit <= rbit + 3'd1;
          if (rbit == 3'd7) rx_state <= STOP;
        end
        if (rx_state == STOP && rtcnt == 4'hf) begin
          rx_state <= IDLE;
          rx_wait  <= !s2;
        end
      end
    end
  // a receiver set in the same cycle as a write-1-to-clear takes priority
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      rx_data   <= '0;
    end else begin
      rx_valid  <= rx_load || (rx_valid && !(wr_st && wdata[ST_RX_VALID]));
      frame_err <= rx_ferr || (frame_err && !(wr_st && wdata[ST_FRAME_ERR]));
      overrun   <= (rx_load && rx_valid) || (overrun && !(wr_st && wdata[ST_OVERRUN]));
      rx_data   <= rx_load ? rsh : rx_data;
    end
`else
  logic unused_rxd;
  assign unused_rxd = rxd;
  assign rx_valid   = 1'b0;
  assign frame_err  = 1'b0;
  assign overrun    = 1'b0;
  assign rx_data    = '0;
`endif
  always_comb begin
    status                  = '0;
    status[ST_BUSY]         = tx_busy;
    status[ST_RX_VALID]     = rx_valid;
    status[ST_FRAME_ERR]    = frame_err;
    status[ST_OVERRUN]      = overrun;
    status[ST_RX_DATA +: 8] = rx_data;
    rdata = !hit ? '0 :
            addr[1:0] == REG_CTRL   ? {31'b0, uart_en} :
            addr[1:0] == REG_TXDATA ? {24'b0, tx_data} :
            addr[1:0] == REG_STATUS ? status : baud;
  end
endmodule

// File: tb/tb_uart_top.sv
// tb_uart_top: register vectors, randomized register traffic, TX/RX frames, abort and async reset.
module tb_uart_top;
  logic        clk = 1'b0, rst_n = 1'b0, rxd = 1'b1, sel = 1'b0;
  logic [13:0] addr = '0;
  logic [3:0]  we = '0;
  logic [31:0] wdata = '0;
  logic        txd;
  logic [31:0] rdata;
  int errors = 0, checks = 0;
  localparam int D = 55;

  uart_top dut (.clk(clk), .rst_n(rst_n), .rxd(rxd), .txd(txd), .sel(sel),
                .addr(addr), .we(we), .wdata(wdata), .rdata(rdata));

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] a;
    logic [3:0]  w;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic s, input logic [13:0] a, input logic [3:0] w, input logic [31:0] d);
    sel = s; addr = a; we = w; wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; we = '0;
  endtask

  task automatic rd(input logic [13:0] a, output logic [31:0] d);
    sel = 1'b1; addr = a; we = '0;
    #1 d = rdata;
    sel = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] frame(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // Expected txd per clock follows from the 8N1 bit order and 16*D clocks per bit.
  task automatic tx_frame(input logic [7:0] b, input string nm);
    logic [9:0]  fr;
    logic [31:0] st;
    int bad[10] = '{default: 0};
    int busy_n = 0;
    fr = frame(b);
    @(posedge clk); #1;
    for (int c = 0; c < 160 * D; c++) begin
      if (txd !== fr[c / (16 * D)]) bad[c / (16 * D)]++;
      rd(14'd2, st);
      if (st[0]) busy_n++;
      @(posedge clk); #1;
    end
    for (int k = 0; k < 10; k++) check($sformatf("%s bit%0d wrong-clock count", nm, k), 32'(bad[k]), 32'd0);
    check({nm, " busy clocks"}, 32'(busy_n), 32'(160 * D));
    rd(14'd2, st);
    check({nm, " busy after"}, {31'b0, st[0]}, 32'd0);
    check({nm, " txd after"}, {31'b0, txd}, 32'd1);
  endtask

  task automatic rx_send(input logic [9:0] fr);
    for (int k = 0; k < 10; k++) begin
      rxd = fr[k];
      repeat (16 * D) @(posedge clk);
    end
    #1;
  endtask

  logic [31:0] r, m_ctrl, m_tx, m_baud;
  vec_t tbl[9];
  logic        m_valid, m_ferr, m_ovr;
  logic [7:0]  m_data, b;

  function automatic logic [31:0] m_status();
    return {16'h0, m_data, 4'h0, m_ovr, m_ferr, m_valid, 1'b0};
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd(14'(i), r);
      check($sformatf("reset word%0d", i), r, 32'h0);
    end
    check("reset txd", {31'b0, txd}, 32'd1);
    idle(1);

    tbl = '{
      '{14'd1, 4'h1, 32'h000000AA, 32'h000000AA},
      '{14'd1, 4'h1, 32'h000000FF, 32'h000000FF},
      '{14'd1, 4'h1, 32'h00000000, 32'h00000000},
      '{14'd1, 4'h1, 32'hFFFFFF55, 32'h00000055},
      '{14'd3, 4'hF, 32'hAAAAAAAA, 32'hAAAAAAAA},
      '{14'd3, 4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF},
      '{14'd3, 4'hF, 32'h00000000, 32'h00000000},
      '{14'd3, 4'hF, 32'h55555555, 32'h55555555},
      '{14'd3, 4'h2, 32'h0000AB00, 32'h5555AB55}
    };
    for (int i = 0; i < 9; i++) begin
      wr(1'b1, tbl[i].a, tbl[i].w, tbl[i].d);
      rd(tbl[i].a, r);
      check($sformatf("vec%0d readback", i), r, tbl[i].exp);
    end
    sel = 1'b0; addr = 14'd3;
    #1 check("sel=0 rdata", rdata, 32'h0);
    rd(14'd2, r);
    check("no frame while disabled", r, 32'h0);
    check("txd idle while disabled", {31'b0, txd}, 32'd1);

    m_ctrl = 32'h0; m_tx = 32'h55; m_baud = 32'h5555AB55;
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  wd;
      logic [13:0] a;
      logic [3:0]  w;
      logic [31:0] d;
      logic        s;
      wd = 2'($urandom_range(0, 3));
      a  = $urandom_range(0, 3) == 0 ? {12'($urandom_range(1, 4095)), wd} : {12'd0, wd};
      s  = $urandom_range(0, 4) != 0;
      w  = 4'($urandom);
      d  = $urandom;
      if (wd == 2'd0) d[0] = 1'b0;
      wr(s, a, w, d);
      if (s && a[13:2] == 12'd0) begin
        if (wd == 2'd0 && w[0]) m_ctrl = {31'b0, d[0]};
        if (wd == 2'd1 && w[0]) m_tx = {24'b0, d[7:0]};
        if (wd == 2'd3)
          for (int k = 0; k < 4; k++) if (w[k]) m_baud[8*k +: 8] = d[8*k +: 8];
      end
      wd = 2'($urandom_range(0, 3));
      rd({12'd0, wd}, r);
      check($sformatf("rand%0d word%0d", i, wd), r,
            wd == 2'd0 ? m_ctrl : wd == 2'd1 ? m_tx : wd == 2'd2 ? 32'h0 : m_baud);
      if (i % 8 == 0) begin
        rd({12'($urandom_range(1, 4095)), wd}, r);
        check($sformatf("rand%0d outside window", i), r, 32'h0);
      end
    end

    wr(1'b1, 14'd3, 4'hF, 32'(D));
    wr(1'b1, 14'd0, 4'h1, 32'h1);
    wr(1'b1, 14'd1, 4'h1, 32'h41);
    tx_frame(8'h41, "tx41");
    wr(1'b1, 14'd1, 4'h1, 32'h42);
    tx_frame(8'h42, "tx42");

`ifdef UART_RX_EN
    m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_data = 8'h0;
    rx_send(frame(8'h3C));
    m_valid = 1'b1; m_data = 8'h3C;
    rd(14'd2, r);
    check("rx 3C status", r, 32'h3C02);
    check("rx 3C model", m_status(), 32'h3C02);
    wr(1'b1, 14'd2, 4'h1, 32'h2);
    m_valid = 1'b0;
    rd(14'd2, r);
    check("rx_valid cleared", r, m_status());
    b = 8'($urandom);
    rx_send(frame(b));
    if (m_valid) m_ovr = 1'b1;
    m_valid = 1'b1; m_data = b;
    rd(14'd2, r);
    check("rx random byte", r, m_status());
    rx_send(10'h000);
    m_ferr = 1'b1;
    rxd = 1'b1;
    idle(16 * D);
    rd(14'd2, r);
    check("rx frame error", r, m_status());
    b = 8'($urandom);
    rx_send(frame(b));
    if (m_valid) m_ovr = 1'b1;
    m_valid = 1'b1; m_data = b;
    rd(14'd2, r);
    check("rx overrun", r, m_status());
    wr(1'b1, 14'd2, 4'h1, 32'hE);
    m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    rd(14'd2, r);
    check("status w1c all", r, m_status());
`else
    rx_send(frame(8'h3C));
    rd(14'd2, r);
    check("rx ignored", r, 32'h0);
`endif

    wr(1'b1, 14'd1, 4'h1, 32'h0F);
    idle(100);
    check("abort pre txd", {31'b0, txd}, 32'd0);
    wr(1'b1, 14'd1, 4'h1, 32'h99);
    rd(14'd1, r);
    check("write while busy updates reg", r, 32'h99);
    rd(14'd2, r);
    check("still busy", r & 32'h1, 32'h1);
    wr(1'b1, 14'd0, 4'h1, 32'h0);
    check("abort txd", {31'b0, txd}, 32'd1);
    rd(14'd2, r);
    check("abort busy", r & 32'h1, 32'h0);
    idle(20);
    check("abort stays idle", {31'b0, txd}, 32'd1);

    wr(1'b1, 14'd0, 4'h1, 32'h1);
    wr(1'b1, 14'd1, 4'h1, 32'h00);
    idle(200);
    check("pre-reset txd", {31'b0, txd}, 32'd0);
    #2 rst_n = 1'b0;
    #1 check("async reset txd", {31'b0, txd}, 32'd1);
    rd(14'd3, r);
    check("async reset baud", r, 32'h0);
    rd(14'd0, r);
    check("async reset ctrl", r, 32'h0);
    rd(14'd2, r);
    check("async reset status", r, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
